// File: rtl/field_scan_pkg.sv
// Shared types, default parameters and scan-direction helpers for field_scan_ctrl.
// Optional feature macro: SCAN_REVERSE_EN (descending scan DEPTH-1 .. 0).
package field_scan_pkg;

  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DEF_WIDTH     = 12;
  localparam int unsigned DEF_FIELD_LSB = 4;
  localparam int unsigned DEF_FIELD_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // Index presented in the first SEND cycle of a scan.
  function automatic int unsigned first_idx(input int unsigned depth);
`ifdef SCAN_REVERSE_EN
    return depth - 1;
`else
    return 0;
`endif
  endfunction

  // Index whose handshake ends the scan.
  function automatic int unsigned last_idx(input int unsigned depth);
`ifdef SCAN_REVERSE_EN
    return 0;
`else
    return depth - 1;
`endif
  endfunction

endpackage

// File: rtl/field_scan_ctrl_regfile.sv
// DEPTH x WIDTH entry array: single write port, async clear, combinational
// field read at an index.
module field_scan_regfile
  import field_scan_pkg::*;
#(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned FIELD_LSB = DEF_FIELD_LSB,
  parameter int unsigned FIELD_W   = DEF_FIELD_W,
  parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_addr_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [FIELD_W-1:0] rd_field_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Entry storage: cleared on reset, updated on a gated write strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Field extraction from the selected entry.
  always_comb begin
    rd_field_o = FIELD_W'(mem_q[rd_idx_i] >> FIELD_LSB);
  end

endmodule

// File: rtl/field_scan_ctrl.sv
// Scan sequencer: freezes the entry array while busy and streams one bit-field
// per entry to the consumer over valid/ready.
// Optional feature macro: SCAN_REVERSE_EN (descending scan order).
module field_scan_ctrl
  import field_scan_pkg::*;
#(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned FIELD_LSB = DEF_FIELD_LSB,
  parameter int unsigned FIELD_W   = DEF_FIELD_W
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic                     wr_drop_o,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     field_valid_o,
  input  logic                     field_ready_i,
  output logic [$clog2(DEPTH)-1:0] field_idx_o,
  output logic [FIELD_W-1:0]       field_data_o,
  output logic                     done_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(first_idx(DEPTH));
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(last_idx(DEPTH));

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             drop_q, drop_d;
  logic             wr_accept;

  field_scan_regfile #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .FIELD_LSB (FIELD_LSB),
    .FIELD_W   (FIELD_W),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wr_en_i    (wr_accept),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .rd_idx_i   (idx_q),
    .rd_field_o (field_data_o)
  );

  // State, index and write-drop flag registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state, index advance and write gating.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_accept = 1'b0;
    drop_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_accept = wr_en_i;
        if (start_i) begin
          state_d = SEND;
          idx_d   = FIRST_IDX;
        end
      end
      SEND: begin
        drop_d = wr_en_i;
        if (field_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
`ifdef SCAN_REVERSE_EN
            idx_d = idx_q - IDX_W'(1);
`else
            idx_d = idx_q + IDX_W'(1);
`endif
          end
        end
      end
      DONE: begin
        drop_d  = wr_en_i;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign field_valid_o = (state_q == SEND);
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign field_idx_o   = idx_q;
  assign wr_drop_o     = drop_q;

endmodule

// File: tb/tb_field_scan_ctrl.sv
// Self-checking bench for field_scan_ctrl against a transaction-level model.
// Honors SCAN_REVERSE_EN when defined for the whole build.
module tb_field_scan_ctrl;

  localparam int DEPTH = 4;
  localparam int WIDTH = 12;
  localparam int FLSB  = 4;
  localparam int FW    = 2;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_drop;
  logic             start;
  logic             busy;
  logic             fvalid;
  logic             fready;
  logic [AW-1:0]    fidx;
  logic [FW-1:0]    fdata;
  logic             done;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] ref_mem [DEPTH];
  int got_by_idx [DEPTH];

  field_scan_ctrl #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .FIELD_LSB (FLSB),
    .FIELD_W   (FW)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .wr_drop_o     (wr_drop),
    .start_i       (start),
    .busy_o        (busy),
    .field_valid_o (fvalid),
    .field_ready_i (fready),
    .field_idx_o   (fidx),
    .field_data_o  (fdata),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int fld(input logic [WIDTH-1:0] v);
    return int'((v >> FLSB) & ((1 << FW) - 1));
  endfunction

  // k-th entry visited by a scan.
  function automatic int order_idx(input int k);
`ifdef SCAN_REVERSE_EN
    return DEPTH - 1 - k;
`else
    return k;
`endif
  endfunction

  task automatic idle_write(input int a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    ref_mem[a] = d;
    tick();
    wr_en = 1'b0;
    chk("idle_write_nodrop", wr_drop, 0);
  endtask

  // mode 0: ready held high; 1: 3 stall cycles at the second field; 2: random.
  // blocked_wr: on the first SEND cycle attempt writing FFF to entry 2.
  // abort_idx: assert reset when that index is presented (-1 = never).
  task automatic run_scan(input int mode, input bit blocked_wr, input bit co_write,
                          input int co_addr, input logic [WIDTH-1:0] co_data,
                          input int abort_idx);
    int exp_i [DEPTH];
    int exp_d [DEPTH];
    int k;
    int stall;
    bit prev_wr;
    logic [WIDTH-1:0] snap [DEPTH];
    if (co_write) begin
      wr_en = 1'b1; wr_addr = AW'(co_addr); wr_data = co_data;
      ref_mem[co_addr] = co_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_i[i] = order_idx(i);
      exp_d[i] = fld(ref_mem[order_idx(i)]);
      got_by_idx[i] = -1;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    k = 0; stall = 0; prev_wr = 1'b0;
    for (int cyc = 0; cyc < 64 && k < DEPTH; cyc++) begin
      chk("send_valid", fvalid, 1);
      chk("send_busy", busy, 1);
      chk("send_nodone", done, 0);
      chk("send_idx", fidx, exp_i[k]);
      chk("send_data", fdata, exp_d[k]);
      chk("send_drop", wr_drop, prev_wr);
      got_by_idx[exp_i[k]] = int'(fdata);
      if (abort_idx == exp_i[k]) begin
        rst_n = 1'b0;
        #1;
        chk("abort_valid", fvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        return;
      end
      case (mode)
        0: fready = 1'b1;
        1: if (k == 1 && stall < 3) begin fready = 1'b0; stall++; end
           else fready = 1'b1;
        default: fready = 1'($urandom_range(0, 1));
      endcase
      if (blocked_wr && cyc == 0) begin
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 12'hFFF;
      end else if (mode == 2 && $urandom_range(0, 2) == 0) begin
        wr_en = 1'b1; wr_addr = AW'($urandom); wr_data = WIDTH'($urandom);
      end
      prev_wr = wr_en;
      tick();
      wr_en = 1'b0;
      if (fready) k++;
    end
    fready = 1'b0;
    if (k < DEPTH) begin
      chk("scan_timeout", 0, 1);
      return;
    end
    // DONE cycle: start must be ignored, writes dropped.
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_valid", fvalid, 0);
    chk("done_drop", wr_drop, prev_wr);
    for (int i = 0; i < DEPTH; i++) snap[i] = ref_mem[i];
    start = 1'b1;
    wr_en = 1'b1; wr_addr = AW'($urandom); wr_data = WIDTH'($urandom);
    tick();
    start = 1'b0; wr_en = 1'b0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_drop", wr_drop, 1);
    tick();
    chk("start_not_queued", fvalid, 0);
    chk("idle_busy", busy, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = snap[i];
  endtask

  initial begin
    rst_n = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; start = 0; fready = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_valid", fvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", wr_drop, 0);
    chk("rst_idx", fidx, 0);
    chk("rst_data", fdata, 0);
    rst_n = 1'b1;
    tick();

    // Basic scan.
    idle_write(0, 12'h012); idle_write(1, 12'h345);
    idle_write(2, 12'h678); idle_write(3, 12'h9AB);
    run_scan(0, 1'b0, 1'b0, 0, '0, -1);
    chk("basic_f0", got_by_idx[0], 1);
    chk("basic_f1", got_by_idx[1], 0);
    chk("basic_f2", got_by_idx[2], 3);
    chk("basic_f3", got_by_idx[3], 2);

    // Backpressure.
    run_scan(1, 1'b0, 1'b0, 0, '0, -1);
    chk("bp_f1", got_by_idx[1], 0);
    chk("bp_f2", got_by_idx[2], 3);

    // Write during scan is dropped; entry 2 keeps 12'h678.
    run_scan(0, 1'b1, 1'b0, 0, '0, -1);
    chk("wr_busy_f2", got_by_idx[2], 3);
    run_scan(0, 1'b0, 1'b0, 0, '0, -1);
    chk("wr_busy_after_f2", got_by_idx[2], 3);

    // Simultaneous write and start.
    run_scan(0, 1'b0, 1'b1, 0, 12'h030, -1);
    chk("co_write_f0", got_by_idx[0], 3);

    // Reset mid-scan at idx 2.
    run_scan(0, 1'b0, 1'b0, 0, '0, 2);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("in_rst_done", done, 0);
      chk("in_rst_valid", fvalid, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("rel_done", done, 0);
    run_scan(0, 1'b0, 1'b0, 0, '0, -1);
    for (int i = 0; i < DEPTH; i++) chk("rescan_zero", got_by_idx[i], 0);

    // Randomized scans with random idle writes.
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 3; w++) idle_write(int'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom));
      run_scan(2, 1'b0, 1'b0, 0, '0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/field_scan_ctrl.md
Name: field_scan_ctrl

Overview:
- Owns a DEPTH-entry x WIDTH-bit register array and sequences a scan over it.
- For each entry, presents one bit-field `entry[FIELD_LSB +: FIELD_W]` to a downstream consumer over a valid/ready handshake.
- Sits between the config-write path, which loads the entries, and the field consumer.
- Guarantees the array is frozen for the duration of a scan.

Parameters:
- DEPTH, 4: number of entries; power of 2, >= 2.
- WIDTH, 12: entry width in bits.
- FIELD_LSB, 4: LSB of the extracted field.
- FIELD_W, 2: field width; FIELD_LSB + FIELD_W <= WIDTH.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- wr_en_i  in  1  write strobe.
- wr_addr_i  in  $clog2(DEPTH)  write entry index.
- wr_data_i  in  WIDTH  write data.
- wr_drop_o  out  1  1-cycle pulse: a write was rejected because busy.
- start_i  in  1  scan request (level sampled each cycle).
- busy_o  out  1  high from the cycle after start is accepted until after the done cycle.
- field_valid_o  out  1  field output valid.
- field_ready_i  in  1  consumer ready.
- field_idx_o  out  $clog2(DEPTH)  entry index of the current field.
- field_data_o  out  FIELD_W  `entry[field_idx_o][FIELD_LSB +: FIELD_W]`.
- done_o  out  1  1-cycle pulse after the last field handshake.

Behaviour:
- Reset (async assert, sync release):
  - All array entries = 0; state = IDLE; idx = 0.
  - All outputs 0: field_valid_o, field_idx_o, field_data_o, busy_o, done_o, wr_drop_o.
- Reset asserted mid-scan aborts immediately. No done_o pulse, field_valid_o drops asynchronously, array cleared.
- FSM states: IDLE, SEND, DONE.
  - IDLE: `start_i=1` -> SEND, idx = first index (0), busy_o = 1 from the next cycle.
  - SEND:
    - field_valid_o = 1.
    - Handshake = valid & ready.
    - On handshake with idx != last (DEPTH-1): idx advances by 1 and the state stays SEND, so back-to-back fields are possible (one per cycle with ready held high).
    - On handshake at the last index: -> DONE.
    - While valid & !ready: field_idx_o and field_data_o are held stable.
  - DONE: done_o = 1 for exactly one cycle, busy_o = 1, -> IDLE. start_i is ignored in DONE.
- Latency: start sampled at edge N -> field 0 valid in cycle N+1. The minimum scan takes DEPTH+1 cycles including DONE.
- field_data_o is combinational from the registered idx and the array. field_idx_o = idx.
- Writes:
  - Accepted in IDLE only: the entry is updated at the edge.
  - In SEND or DONE the write is discarded and wr_drop_o pulses the next cycle.
- Write and start in the same IDLE cycle: the write is committed at that edge and the scan sees the new value.
- start_i while busy: ignored, not queued.
- Index wrap: idx never exceeds DEPTH-1. The last-index compare uses the full idx width.

Optional Feature:
- SCAN_REVERSE_EN defined:
  - Scan starts at DEPTH-1 and decrements; last index = 0.
  - All handshake, hold and done rules are otherwise unchanged.
- Undefined: ascending scan 0 .. DEPTH-1.

Decomposition:
- Package field_scan_pkg:
  - state enum scan_state_e {IDLE, SEND, DONE};
  - default parameter constants;
  - function first_idx / last_idx, selecting on SCAN_REVERSE_EN.
- Sub-module field_scan_regfile: the DEPTH x WIDTH array with write port, reset clear and combinational field read at an index.
- The FSM, write gating and handshake logic live in field_scan_ctrl.

Test Plan:
- Basic scan:
  - Stimulus: write 12'h012, 12'h345, 12'h678, 12'h9AB to entries 0..3; start; ready held 1.
  - Required: fields 1, 0, 3, 2 on consecutive cycles with idx 0, 1, 2, 3; done_o one cycle after idx 3; busy_o low the cycle after done.
- Backpressure:
  - Stimulus: same data; ready = 0 for 3 cycles at idx 1.
  - Required: idx=1, data=0 held stable for 4 cycles; the next field is 3 at idx 2.
- Write during scan:
  - Stimulus: write 12'hFFF to entry 2 while busy.
  - Required: wr_drop_o pulses; field at idx 2 = 3 (unchanged); after done, entry 2 reads 12'h678.
- Simultaneous write and start:
  - Stimulus: in IDLE, write 12'h030 to entry 0 together with start.
  - Required: first field = 3 at idx 0.
- Reset mid-scan:
  - Stimulus: assert rst_n_i = 0 at idx 2.
  - Required: field_valid_o = 0 with no clock edge; no done_o pulse; a rescan after release yields 0, 0, 0, 0.
- SCAN_REVERSE_EN:
  - Stimulus: the basic scan data.
  - Required: idx 3, 2, 1, 0 with fields 2, 3, 0, 1.
